qmult_arbiter: RTL

QMULT_ARBITER -- requirements
Module: qmult_arbiter

---
 rtl/qmult_arbiter_if.sv | 25 ++
 rtl/qmult_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/qmult_arbiter_if.sv
// Request/operand/result bundle between four requesters, one consumer and qmult_arbiter.
interface qmult_arbiter_if #(
  parameter int N = 32
);
  logic [3:0]     i_req;
  logic [4*N-1:0] i_multiplicand;
  logic [4*N-1:0] i_multiplier;
  logic [3:0]     o_gnt;
  logic [N-1:0]   o_result;
  logic           o_valid;
  logic [1:0]     o_tag;
  logic           i_ready;
  logic           o_ovf;
  logic           o_busy;

  modport slave (
    input  i_req, i_multiplicand, i_multiplier, i_ready,
    output o_gnt, o_result, o_valid, o_tag, o_ovf, o_busy
  );

  modport master (
    output i_req, i_multiplicand, i_multiplier, i_ready,
    input  o_gnt, o_result, o_valid, o_tag, o_ovf, o_busy
  );
endinterface

// File: rtl/qmult_arbiter.sv
// Round-robin arbiter in front of one signed-magnitude Q-format multiplier.
// Define QMULT_ARB_OVF_EN to enable overflow detection and result saturation.
module qmult_arbiter #(
  parameter int Q = 16,
  parameter int N = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  qmult_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a request; grant and operand capture happen here
  // MUL   | multiplying the latched magnitudes
  // DONE  | result presented until the consumer takes it
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      last_grant, winner, cand, owner;
  logic            found;
  logic [N-2:0]    mag_a, mag_b;
  logic            sign;
  logic [2*N-1:0]  prod;
  logic            ovf_raw;
  logic            unused_bits;

  // Cyclic search starting just past the previous winner.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (!found && bus.i_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.i_req) state_nxt = MUL;
      MUL:     state_nxt = DONE;
      DONE:    if (bus.i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant <= 2'd3;
      owner      <= '0;
      mag_a      <= '0;
      mag_b      <= '0;
      sign       <= 1'b0;
      prod       <= '0;
    end else begin
      if (state == IDLE && found) begin
        last_grant <= winner;
        owner      <= winner;
        mag_a      <= bus.i_multiplicand[int'(winner)*N +: N-1];
        mag_b      <= bus.i_multiplier[int'(winner)*N +: N-1];
        sign       <= bus.i_multiplicand[int'(winner)*N + N-1]
                    ^ bus.i_multiplier[int'(winner)*N + N-1];
      end
      if (state == MUL)
        prod <= (2*N)'(mag_a) * (2*N)'(mag_b);
    end
  end

  assign ovf_raw     = |prod[2*N-1:N-1+Q];
  assign unused_bits = ^{prod[Q-1:0], ovf_raw};

  always_comb begin
    bus.o_gnt    = '0;
    bus.o_valid  = 1'b0;
    bus.o_result = '0;
    bus.o_tag    = '0;
    bus.o_ovf    = 1'b0;
    bus.o_busy   = (state != IDLE);
    case (state)
      IDLE: if (found && !i_rst) bus.o_gnt[winner] = 1'b1;
      DONE: begin
        bus.o_valid  = 1'b1;
        bus.o_tag    = owner;
        bus.o_result = {sign, prod[N-2+Q:Q]};
`ifdef QMULT_ARB_OVF_EN
        if (ovf_raw) begin
          bus.o_ovf           = 1'b1;
          bus.o_result[N-2:0] = '1;
        end
`endif
      end
      default: ;
    endcase
  end
endmodule
